mipi_csi2_rx_ctrl: RTL and testbench
====================================

MIPI_CSI2_RX_CTRL -- requirements
Module: mipi_csi2_rx_ctrl

Interface
REQ-001 Parameter MAX_LANES, default 3, data lane count of the controlled deserializer.
REQ-002 Parameter SETTLE_CYCLES, default 16, clk cycles enable is held low while new config is applied (range 1..255).
REQ-003 clk  in  1  deserializer image clock (img_clk); the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_start  in  1  one-cycle pulse, begin capture.
REQ-006 cfg_stop  in  1  one-cycle pulse, stop after the current frame.
REQ-007 cfg_single  in  1  level; 1 = stop after one frame.
REQ-008 cfg_update  in  1  one-cycle pulse, latch the *_req fields below into staging.
REQ-009 cfg_lanes_req  in  3  requested num_active_lanes.
REQ-010 cfg_tx_period_req  in  8  requested mipi_tx_period.
REQ-011 cfg_polarity_req  in  MAX_LANES  requested md_polarity.
REQ-012 cfg_timeout  in  24  frame-start watchdog limit in clk cycles; 0 disables.
REQ-013 err_clear  in  1  pulse, clear sticky errors.
REQ-014 fvo, lvo, dvo  in  1 each  frame, line and pixel strobes from the deserializer (clk domain).
REQ-015 des_enable  out  1  deserializer enable.
REQ-016 num_active_lanes  out  3; mipi_tx_period  out  8; md_polarity  out  MAX_LANES: applied configuration.
REQ-017 busy  out  1  state != IDLE.
REQ-018 frame_done  out  1  one-cycle pulse at frame end.
REQ-019 frame_count  out  16; line_count  out  16; line_width  out  16: status counters.
REQ-020 err_timeout, err_width  out  1 each  sticky error flags.

Function
REQ-021 FSM states: IDLE, APPLY, WAIT_FS, IN_FRAME; all outputs registered.
REQ-022 IDLE: des_enable=0; cfg_start -> APPLY.
REQ-023 APPLY entry cycle: staging copied to num_active_lanes/mipi_tx_period/md_polarity and update_pending cleared; des_enable=0 for exactly SETTLE_CYCLES cycles, then -> WAIT_FS.
REQ-024 WAIT_FS: des_enable=1; watchdog increments each cycle; fvo rising (fvo=1, previous fvo=0) -> IN_FRAME, clear internal line and pixel counters.
REQ-025 Watchdog reaching cfg_timeout (cfg_timeout!=0) in WAIT_FS: err_timeout<=1, -> APPLY (restart); watchdog clears on leaving WAIT_FS.
REQ-026 IN_FRAME: lvo rising increments the internal line counter; dvo=1 while lvo=1 increments the pixel counter.
REQ-027 lvo falling: line_width <= pixel count; if not the first line of the frame and count != previous line's count, err_width<=1; pixel counter cleared.
REQ-028 fvo falling: frame_done=1 for one cycle, frame_count+1 (wraps 0xFFFF->0), line_count <= internal line count.
REQ-029 After frame end: stop_pending or cfg_single -> IDLE; else update_pending -> APPLY; else -> WAIT_FS.
REQ-030 cfg_update in any state latches the *_req fields into staging and sets update_pending; new values never reach the outputs outside APPLY entry.
REQ-031 cfg_stop in WAIT_FS or APPLY -> IDLE next cycle; in IN_FRAME sets stop_pending (frame completes); stop_pending is cleared on entering IDLE.
REQ-032 cfg_start and cfg_stop in the same cycle: stop wins; cfg_start outside IDLE is ignored.
REQ-033 err_clear coincident with an error set: set wins.
REQ-034 Internal counters saturate at 0xFFFF.

Reset
REQ-035 reset: state=IDLE, des_enable=0, applied config and staging = num_active_lanes 1, mipi_tx_period 0, md_polarity 0; all counters, flags and pending bits 0.
REQ-036 reset mid-frame overrides everything on the same edge, and no frame_done pulse is issued.

Structure
REQ-037 State encodings and the reset-default config constants belong in package mipi_pkg.
REQ-038 One sub-module, mipi_line_meter (lvo/dvo edge detect, pixel count, width compare), is instantiated; the FSM stays in the top module.

Verification
REQ-039 Reset, then cfg_start, SETTLE_CYCLES=16 -> des_enable low 16 cycles, high on the 17th.
REQ-040 Frame of 4 lines x 640 dvo -> frame_done single pulse, line_count=4, line_width=640, frame_count=1, err_width=0.
REQ-041 Line widths 640, 640, 639 -> err_width=1, which holds until err_clear.
REQ-042 cfg_timeout=100 and no fvo -> err_timeout=1 at cycle 100 of WAIT_FS, des_enable low for 16 cycles, then re-enabled.
REQ-043 cfg_update lanes=2 mid-frame -> num_active_lanes unchanged until fvo falls, then APPLY sets it to 2.
REQ-044 cfg_stop mid-frame, and cfg_single=1 -> frame completes, frame_done pulses, busy drops the next cycle.

Source files
------------

// File: rtl/mipi_pkg.sv
// ---------------------------------------------------------------------------
// mipi_pkg
// Shared definitions for the CSI-2 receive controller slice:
//   - state_e      : controller FSM state encoding
//   - RST_LANES    : num_active_lanes value after reset
//   - RST_TX_PERIOD: mipi_tx_period value after reset
// md_polarity resets to all zeros; its width depends on the MAX_LANES
// parameter of the top, so it is written as '0 at the point of use.
// ---------------------------------------------------------------------------
package mipi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_APPLY    = 2'd1,
        ST_WAIT_FS  = 2'd2,
        ST_IN_FRAME = 2'd3
    } state_e;

    localparam logic [2:0] RST_LANES     = 3'd1;
    localparam logic [7:0] RST_TX_PERIOD = 8'd0;

endpackage

// File: rtl/mipi_line_meter.sv
// ---------------------------------------------------------------------------
// mipi_line_meter
// Measures lines inside a frame: counts line starts, counts pixels per line
// and flags a line whose width differs from the line before it in the same
// frame. The first line of every frame only establishes the reference width.
// Ports:
//   clk, reset  : image clock, synchronous active-high reset
//   active      : counting enabled (controller is inside a frame)
//   clear       : start of frame, clears line/pixel counters
//   lvo, dvo    : line valid and pixel valid strobes
//   line_cnt    : lines started in the current frame (saturating)
//   line_width  : pixel count of the most recently finished line
//   width_err   : one-cycle pulse, finished line width mismatched
// ---------------------------------------------------------------------------
module mipi_line_meter (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        clear,
    input  logic        lvo,
    input  logic        dvo,
    output logic [15:0] line_cnt,
    output logic [15:0] line_width,
    output logic        width_err
);

    logic        lvo_q;
    logic        first_line;
    logic [15:0] pix_cnt;
    logic        lvo_rise;
    logic        lvo_fall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign lvo_rise = lvo & ~lvo_q;
    assign lvo_fall = ~lvo & lvo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lvo_q      <= 1'b0;
            first_line <= 1'b1;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_width <= '0;
            width_err  <= 1'b0;
        end else begin
            lvo_q     <= lvo;
            width_err <= 1'b0;
            if (clear) begin
                line_cnt   <= '0;
                pix_cnt    <= '0;
                first_line <= 1'b1;
            end else if (active) begin
                if (lvo_rise) begin
                    line_cnt <= sat_inc(line_cnt);
                end
                if (lvo && dvo) begin
                    pix_cnt <= sat_inc(pix_cnt);
                end
                // line_width still holds the previous line's width here
                if (lvo_fall) begin
                    line_width <= pix_cnt;
                    pix_cnt    <= '0;
                    first_line <= 1'b0;
                    if (!first_line && (pix_cnt != line_width)) begin
                        width_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mipi_csi2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// mipi_csi2_rx_ctrl
// Sequences a CSI-2 deserializer: applies staged lane configuration with the
// deserializer held disabled for SETTLE_CYCLES, waits for frame start under
// a watchdog, tracks frames/lines/widths and raises sticky error flags.
// Ports:
//   clk, reset                 : image clock, synchronous active-high reset
//   cfg_start / cfg_stop       : begin capture / stop after current frame
//   cfg_single                 : stop after one frame
//   cfg_update + cfg_*_req     : stage a new lane/timing/polarity config
//   cfg_timeout                : frame-start watchdog limit, 0 disables
//   err_clear                  : clear sticky errors
//   fvo, lvo, dvo              : frame/line/pixel strobes
//   des_enable                 : deserializer enable
//   num_active_lanes, mipi_tx_period, md_polarity : applied config
//   busy, frame_done           : status and end-of-frame pulse
//   frame_count, line_count, line_width : status counters
//   err_timeout, err_width     : sticky error flags
// ---------------------------------------------------------------------------
module mipi_csi2_rx_ctrl
    import mipi_pkg::*;
#(
    parameter int MAX_LANES     = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic                 cfg_single,
    input  logic                 cfg_update,
    input  logic [2:0]           cfg_lanes_req,
    input  logic [7:0]           cfg_tx_period_req,
    input  logic [MAX_LANES-1:0] cfg_polarity_req,
    input  logic [23:0]          cfg_timeout,
    input  logic                 err_clear,
    input  logic                 fvo,
    input  logic                 lvo,
    input  logic                 dvo,
    output logic                 des_enable,
    output logic [2:0]           num_active_lanes,
    output logic [7:0]           mipi_tx_period,
    output logic [MAX_LANES-1:0] md_polarity,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic [15:0]          line_count,
    output logic [15:0]          line_width,
    output logic                 err_timeout,
    output logic                 err_width
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_e               state_q;
    state_e               state_d;
    logic                 fvo_q;
    logic [7:0]           settle_cnt;
    logic [23:0]          wd_cnt;
    logic                 stop_pending;
    logic                 update_pending;
    logic [2:0]           stg_lanes;
    logic [7:0]           stg_tx_period;
    logic [MAX_LANES-1:0] stg_polarity;

    logic                 fvo_rise;
    logic                 fvo_fall;
    logic                 wd_hit;
    logic                 apply_entry;
    logic                 frame_start;
    logic                 frame_end;
    logic                 timeout_err;
    logic [15:0]          meter_line_cnt;
    logic                 meter_width_err;

    assign fvo_rise = fvo & ~fvo_q;
    assign fvo_fall = ~fvo & fvo_q;
    // Widened compare so a limit of 24'hFFFFFF cannot wrap
    assign wd_hit   = (cfg_timeout != 24'd0) &&
                      (({1'b0, wd_cnt} + 25'd1) == {1'b0, cfg_timeout});

    always_comb begin
        state_d     = state_q;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start && !cfg_stop) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                if (cfg_stop)                       state_d = ST_IDLE;
                else if (settle_cnt == SETTLE_LAST) state_d = ST_WAIT_FS;
            end
            ST_WAIT_FS: begin
                if (cfg_stop)      state_d = ST_IDLE;
                else if (fvo_rise) state_d = ST_IN_FRAME;
                else if (wd_hit)   state_d = ST_APPLY;
            end
            ST_IN_FRAME: begin
                if (fvo_fall) begin
                    frame_end = 1'b1;
                    if (stop_pending || cfg_stop || cfg_single) state_d = ST_IDLE;
                    else if (update_pending)                    state_d = ST_APPLY;
                    else                                        state_d = ST_WAIT_FS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign apply_entry = (state_d == ST_APPLY) && (state_q != ST_APPLY);
    assign frame_start = (state_q == ST_WAIT_FS) && (state_d == ST_IN_FRAME);
    assign timeout_err = (state_q == ST_WAIT_FS) && (state_d == ST_APPLY);

    mipi_line_meter u_line_meter (
        .clk        (clk),
        .reset      (reset),
        .active     (state_q == ST_IN_FRAME),
        .clear      (frame_start),
        .lvo        (lvo),
        .dvo        (dvo),
        .line_cnt   (meter_line_cnt),
        .line_width (line_width),
        .width_err  (meter_width_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            fvo_q            <= 1'b0;
            settle_cnt       <= '0;
            wd_cnt           <= '0;
            stop_pending     <= 1'b0;
            update_pending   <= 1'b0;
            stg_lanes        <= RST_LANES;
            stg_tx_period    <= RST_TX_PERIOD;
            stg_polarity     <= '0;
            num_active_lanes <= RST_LANES;
            mipi_tx_period   <= RST_TX_PERIOD;
            md_polarity      <= '0;
            des_enable       <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            frame_count      <= '0;
            line_count       <= '0;
            err_timeout      <= 1'b0;
            err_width        <= 1'b0;
        end else begin
            state_q    <= state_d;
            fvo_q      <= fvo;
            des_enable <= (state_d == ST_WAIT_FS) || (state_d == ST_IN_FRAME);
            busy       <= (state_d != ST_IDLE);
            frame_done <= frame_end;

            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
                line_count  <= meter_line_cnt;
            end

            if (apply_entry) begin
                settle_cnt <= '0;
            end else if (state_q == ST_APPLY) begin
                settle_cnt <= settle_cnt + 8'd1;
            end

            if ((state_q == ST_WAIT_FS) && (state_d == ST_WAIT_FS)) begin
                if (wd_cnt != 24'hFFFFFF) wd_cnt <= wd_cnt + 24'd1;
            end else begin
                wd_cnt <= '0;
            end

            // Applied config copies the staging value present before any
            // coincident cfg_update; that update then stays pending.
            if (apply_entry) begin
                num_active_lanes <= stg_lanes;
                mipi_tx_period   <= stg_tx_period;
                md_polarity      <= stg_polarity;
            end
            if (cfg_update) begin
                stg_lanes      <= cfg_lanes_req;
                stg_tx_period  <= cfg_tx_period_req;
                stg_polarity   <= cfg_polarity_req;
                update_pending <= 1'b1;
            end else if (apply_entry) begin
                update_pending <= 1'b0;
            end

            if (state_d == ST_IDLE) begin
                stop_pending <= 1'b0;
            end else if ((state_q == ST_IN_FRAME) && cfg_stop) begin
                stop_pending <= 1'b1;
            end

            // A set in the same cycle as err_clear takes priority
            if (timeout_err)    err_timeout <= 1'b1;
            else if (err_clear) err_timeout <= 1'b0;

            if (meter_width_err) err_width <= 1'b1;
            else if (err_clear)  err_width <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mipi_csi2_rx_ctrl.sv
module tb_mipi_csi2_rx_ctrl;

    localparam int MAX_LANES = 3;
    localparam int SETTLE    = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cfg_start, cfg_stop, cfg_single, cfg_update;
    logic [2:0]           cfg_lanes_req;
    logic [7:0]           cfg_tx_period_req;
    logic [MAX_LANES-1:0] cfg_polarity_req;
    logic [23:0]          cfg_timeout;
    logic                 err_clear;
    logic                 fvo, lvo, dvo;
    logic                 des_enable;
    logic [2:0]           num_active_lanes;
    logic [7:0]           mipi_tx_period;
    logic [MAX_LANES-1:0] md_polarity;
    logic                 busy, frame_done;
    logic [15:0]          frame_count, line_count, line_width;
    logic                 err_timeout, err_width;

    always #5 clk = ~clk;

    mipi_csi2_rx_ctrl #(
        .MAX_LANES     (MAX_LANES),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .cfg_single        (cfg_single),
        .cfg_update        (cfg_update),
        .cfg_lanes_req     (cfg_lanes_req),
        .cfg_tx_period_req (cfg_tx_period_req),
        .cfg_polarity_req  (cfg_polarity_req),
        .cfg_timeout       (cfg_timeout),
        .err_clear         (err_clear),
        .fvo               (fvo),
        .lvo               (lvo),
        .dvo               (dvo),
        .des_enable        (des_enable),
        .num_active_lanes  (num_active_lanes),
        .mipi_tx_period    (mipi_tx_period),
        .md_polarity       (md_polarity),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .line_count        (line_count),
        .line_width        (line_width),
        .err_timeout       (err_timeout),
        .err_width         (err_width)
    );

    typedef struct {
        int   fc;
        int   lc;
        int   lw;
        logic ew;
    } frame_exp_t;

    frame_exp_t sb[$];
    frame_exp_t e;
    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    int cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int fc, input int lc, input int lw, input logic ew);
        frame_exp_t x;
        x.fc = fc; x.lc = lc; x.lw = lw; x.ew = ew;
        sb.push_back(x);
    endtask

    task automatic send_line(input int w);
        lvo = 1'b1; dvo = 1'b1;
        repeat (w) step();
        lvo = 1'b0; dvo = 1'b0;
        step();
        step();
    endtask

    task automatic frame_begin();
        fvo = 1'b1;
        step();
        step();
    endtask

    task automatic frame_end();
        fvo = 1'b0;
        step();
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (des_enable === 1'b0 && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic measure_high(output int n);
        n = 0;
        while (des_enable === 1'b1 && n < 2000) begin
            n++;
            step();
        end
    endtask

    // Scoreboard consumer: every frame_done pulse retires one expected frame
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            n_done++;
            check("frame_done_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("frame_count", frame_count, e.fc);
                check("line_count",  line_count,  e.lc);
                check("line_width",  line_width,  e.lw);
                check("err_width_at_done", err_width, e.ew);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1;
        cfg_start = 0; cfg_stop = 0; cfg_single = 0; cfg_update = 0;
        cfg_lanes_req = 0; cfg_tx_period_req = 0; cfg_polarity_req = 0;
        cfg_timeout = 0; err_clear = 0; fvo = 0; lvo = 0; dvo = 0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_des_enable", des_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_lanes", num_active_lanes, 1);
        check("rst_tx_period", mipi_tx_period, 0);
        check("rst_polarity", md_polarity, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_errors", {err_timeout, err_width}, 0);

        // Start: enable low for SETTLE cycles, then high
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        measure_low(cnt);
        check("start_settle_low", cnt, SETTLE);
        check("start_enable_high", des_enable, 1);
        check("start_busy", busy, 1);

        // 4 lines x 640
        push_frame(1, 4, 640, 1'b0);
        frame_begin();
        repeat (4) send_line(640);
        frame_end();
        check("f1_done_pulse", frame_done, 1);
        step();
        check("f1_done_single", frame_done, 0);
        check("f1_back_to_wait", {busy, des_enable}, 2'b11);

        // Widths 640, 640, 639 -> width error, sticky until cleared
        push_frame(2, 3, 639, 1'b1);
        frame_begin();
        send_line(640);
        send_line(640);
        send_line(639);
        frame_end();
        repeat (5) step();
        check("werr_sticky", err_width, 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("werr_cleared", err_width, 0);

        // Single-line frame: first line never flags, even though it
        // differs from the previous frame's last line
        push_frame(3, 1, 5, 1'b0);
        frame_begin();
        send_line(5);
        frame_end();
        step();
        check("first_line_no_err", err_width, 0);

        // Mid-frame config update applies only at the following APPLY
        push_frame(4, 2, 8, 1'b0);
        frame_begin();
        send_line(8);
        cfg_lanes_req = 3'd2; cfg_tx_period_req = 8'h5A; cfg_polarity_req = 3'b101;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check("upd_lanes_held", num_active_lanes, 1);
        check("upd_tx_held", mipi_tx_period, 0);
        send_line(8);
        frame_end();
        check("upd_lanes_applied", num_active_lanes, 2);
        check("upd_tx_applied", mipi_tx_period, 8'h5A);
        check("upd_pol_applied", md_polarity, 3'b101);
        check("upd_enable_low", des_enable, 0);
        cfg_timeout = 24'd100;
        measure_low(cnt);
        check("upd_settle_low", cnt, SETTLE);

        // Watchdog: 100 cycles in WAIT_FS with no frame start
        measure_high(cnt);
        check("wd_high_cycles", cnt, 100);
        check("wd_err_timeout", err_timeout, 1);
        cfg_timeout = 24'd0;
        measure_low(cnt);
        check("wd_restart_low", cnt, SETTLE);
        check("wd_reenabled", des_enable, 1);
        check("wd_err_held", err_timeout, 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("wd_err_cleared", err_timeout, 0);

        // Stop mid-frame: frame completes, then idle
        push_frame(5, 2, 4, 1'b0);
        frame_begin();
        send_line(4);
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        check("stop_still_busy", busy, 1);
        send_line(4);
        frame_end();
        check("stop_done_pulse", frame_done, 1);
        check("stop_idle", {busy, des_enable}, 2'b00);
        step();
        check("stop_done_single", frame_done, 0);

        // Single-frame mode
        cfg_single = 1'b1;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        measure_low(cnt);
        check("single_settle_low", cnt, SETTLE);
        push_frame(6, 1, 3, 1'b0);
        frame_begin();
        send_line(3);
        frame_end();
        check("single_idle", busy, 0);
        cfg_single = 1'b0;
        step();

        // Start and stop together: stop wins
        cfg_start = 1'b1; cfg_stop = 1'b1;
        step();
        cfg_start = 1'b0; cfg_stop = 1'b0;
        check("start_stop_same", busy, 0);

        // Stop during APPLY
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        step();
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        check("stop_in_apply", busy, 0);

        // Stop during WAIT_FS
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        measure_low(cnt);
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        check("stop_in_wait", {busy, des_enable}, 2'b00);

        // err_clear coincident with a timeout: set wins
        cfg_timeout = 24'd3;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        measure_low(cnt);
        step();
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("set_beats_clear", err_timeout, 1);
        cfg_timeout = 24'd0;
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("clear_after_set", err_timeout, 0);

        // Reset on the same edge as frame end: no frame_done
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        measure_low(cnt);
        frame_begin();
        send_line(5);
        lvo = 1'b1; dvo = 1'b1;
        step();
        step();
        reset = 1'b1; fvo = 1'b0; lvo = 1'b0; dvo = 1'b0;
        step();
        check("rst_mid_no_done", frame_done, 0);
        check("rst_mid_idle", {busy, des_enable}, 2'b00);
        check("rst_mid_frame_count", frame_count, 0);
        check("rst_mid_lanes", num_active_lanes, 1);
        check("rst_mid_width", line_width, 0);
        reset = 1'b0;
        step();
        step();

        check("sb_drained", sb.size(), 0);
        check("done_pulses", n_done, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
